// File: rtl/window_pkg.sv
// rtl/window_pkg.sv - shared constants and helpers for the sliding-window generator
package window_pkg;

  localparam int COORD_W   = 16;
  localparam int KSIZE_MIN = 3;
  localparam int KSIZE_MAX = 7;

  function automatic int clog2(input int value);
    int bits;
    bits = 0;
    for (int v = value - 1; v > 0; v = v >>> 1) bits++;
    return (bits == 0) ? 1 : bits;
  endfunction

  function automatic int tap_idx(input int r, input int c, input int k);
    return r * k + c;
  endfunction

endpackage

// File: rtl/line_buffer_ram.sv
// rtl/line_buffer_ram.sv - simple dual-port RAM, asynchronous read, synchronous write
module line_buffer_ram
  import window_pkg::*;
#(
  parameter int DEPTH = 640,
  parameter int WIDTH = 16,
  parameter int AW    = clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  assign rdata = mem[raddr];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

endmodule

// File: rtl/window_generator.sv
// rtl/window_generator.sv - KxK raster sliding-window generator with border masking
// Optional WINDOW_REPLICATE_EN: out-of-frame taps replicate the nearest in-frame pixel.
module window_generator
  import window_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int FRAME_WIDTH  = 640,
  parameter int FRAME_HEIGHT = 480,
  parameter int KSIZE        = 3
) (
  input  logic                                clk,
  input  logic                                reset_n,
  input  logic                                in_valid,
  input  logic                                in_sof,
  input  logic [DATA_WIDTH-1:0]               in_data,
  output logic                                out_valid,
  output logic [KSIZE*KSIZE*DATA_WIDTH-1:0]   out_window,
  output logic [COORD_W-1:0]                  out_x,
  output logic [COORD_W-1:0]                  out_y,
  output logic                                out_border
);

  localparam int AW = clog2(FRAME_WIDTH);
  localparam int RW = (KSIZE - 1) * DATA_WIDTH;
  localparam int WW = KSIZE * KSIZE * DATA_WIDTH;
  localparam logic [COORD_W-1:0] X_LAST = COORD_W'(FRAME_WIDTH - 1);
  localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(FRAME_HEIGHT - 1);

  logic [COORD_W-1:0]    x_cnt, y_cnt, cur_x, cur_y, nxt_x, nxt_y;
  logic                  sof_hit;
  logic [RW-1:0]         rd_word, wr_word;
  logic [DATA_WIDTH-1:0] win_q [KSIZE][KSIZE];
  logic [DATA_WIDTH-1:0] nw    [KSIZE][KSIZE];
  logic [WW-1:0]         win_d;
  logic                  border_d;
  int                    xi, yi;

  // A qualified sof pins the accepted pixel to (0,0) whatever the counters say.
  assign sof_hit = in_valid & in_sof;
  assign cur_x   = sof_hit ? '0 : x_cnt;
  assign cur_y   = sof_hit ? '0 : y_cnt;
  assign xi      = int'(cur_x);
  assign yi      = int'(cur_y);

  always_comb begin
    nxt_x = cur_x + 1'b1;
    nxt_y = cur_y;
    if (cur_x == X_LAST) begin
      nxt_x = '0;
      nxt_y = (cur_y == Y_LAST) ? '0 : cur_y + 1'b1;
    end
  end

  // Oldest stored row sits in the top slot; the new pixel enters at the bottom.
  assign wr_word = {rd_word[RW-DATA_WIDTH-1:0], in_data};

  line_buffer_ram #(
    .DEPTH (FRAME_WIDTH),
    .WIDTH (RW),
    .AW    (AW)
  ) u_line_buffer_ram (
    .clk   (clk),
    .we    (in_valid),
    .waddr (cur_x[AW-1:0]),
    .wdata (wr_word),
    .raddr (cur_x[AW-1:0]),
    .rdata (rd_word)
  );

  always_comb begin
    for (int r = 0; r < KSIZE; r++) begin
      for (int c = 0; c < KSIZE - 1; c++) nw[r][c] = win_q[r][c+1];
    end
    for (int r = 0; r < KSIZE - 1; r++)
      nw[r][KSIZE-1] = rd_word[(KSIZE-2-r)*DATA_WIDTH +: DATA_WIDTH];
    nw[KSIZE-1][KSIZE-1] = in_data;
  end

  assign border_d = (xi < KSIZE - 1) || (yi < KSIZE - 1);

`ifdef WINDOW_REPLICATE_EN
  logic [DATA_WIDTH-1:0] cw [KSIZE][KSIZE];
  logic [DATA_WIDTH-1:0] pix;

  // Column clamp to column KSIZE-1-x first, then row clamp to row KSIZE-1-y.
  always_comb begin
    win_d = '0;
    pix   = '0;
    for (int r = 0; r < KSIZE; r++) begin
      for (int c = 0; c < KSIZE; c++) begin
        cw[r][c] = nw[r][c];
        if (c + xi < KSIZE - 1) begin
          for (int k = 0; k < KSIZE; k++)
            if (k + xi == KSIZE - 1) cw[r][c] = nw[r][k];
        end
      end
    end
    for (int r = 0; r < KSIZE; r++) begin
      for (int c = 0; c < KSIZE; c++) begin
        pix = cw[r][c];
        if (r + yi < KSIZE - 1) begin
          for (int k = 0; k < KSIZE; k++)
            if (k + yi == KSIZE - 1) pix = cw[k][c];
        end
        win_d[tap_idx(r, c, KSIZE)*DATA_WIDTH +: DATA_WIDTH] = pix;
      end
    end
  end
`else
  always_comb begin
    win_d = '0;
    for (int r = 0; r < KSIZE; r++) begin
      for (int c = 0; c < KSIZE; c++) begin
        if ((r + yi >= KSIZE - 1) && (c + xi >= KSIZE - 1))
          win_d[tap_idx(r, c, KSIZE)*DATA_WIDTH +: DATA_WIDTH] = nw[r][c];
      end
    end
  end
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x_cnt <= '0;
      y_cnt <= '0;
      win_q <= '{default: '0};
    end else if (in_valid) begin
      x_cnt <= nxt_x;
      y_cnt <= nxt_y;
      win_q <= nw;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid  <= 1'b0;
      out_window <= '0;
      out_x      <= '0;
      out_y      <= '0;
      out_border <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        out_window <= win_d;
        out_x      <= cur_x;
        out_y      <= cur_y;
        out_border <= border_d;
      end
    end
  end

endmodule

// File: doc/window_generator.md
# window_generator

Parametrised K×K sliding-window generator for the streaming pixel pipeline. It generalises the fixed 3×3 shift-register-plus-FIFO row buffering that feeds the edge and labelling stages. It accepts one raster-ordered pixel per valid cycle and emits the full K×K neighbourhood anchored at that pixel, with its frame coordinates and a border flag. It sits between colour conversion and any windowed operator (Sobel, blur, morphology).

## Interface
- `DATA_WIDTH`, 8, bits per pixel
- `FRAME_WIDTH`, 640, pixels per row (≥ KSIZE)
- `FRAME_HEIGHT`, 480, rows per frame (≥ KSIZE)
- `KSIZE`, 3, window side; odd, 3..7
- `clk`  input  1  clock; all state on rising edge
- `reset_n`  input  1  asynchronous, active-low reset
- `in_valid`  input  1  pixel accepted this cycle
- `in_sof`  input  1  start of frame; qualified by `in_valid`; marks pixel (0,0)
- `in_data`  input  DATA_WIDTH  pixel value
- `out_valid`  output  1  window valid
- `out_window`  output  KSIZE*KSIZE*DATA_WIDTH  tap t=r*KSIZE+c at `[t*DATA_WIDTH +: DATA_WIDTH]`; r=0 oldest row, c=0 leftmost column; tap KSIZE²−1 is the current pixel
- `out_x`, `out_y`  output  16 each  coordinates of the anchor (current) pixel
- `out_border`  output  1  window extends outside the frame (`out_x` < KSIZE−1 or `out_y` < KSIZE−1)

## Operation
- Column counter x runs 0..FRAME_WIDTH−1, and row counter y runs 0..FRAME_HEIGHT−1. Both advance only on accepted pixels.
  - x wraps to 0 and increments y.
  - On the pixel after (FRAME_WIDTH−1, FRAME_HEIGHT−1), both counters wrap to 0. This is an implicit new frame.
- `in_sof` with `in_valid` forces the accepted pixel to (0,0), regardless of the counters. A mid-frame sof abandons the partial frame. No flush is required.
- Line store: one RAM, FRAME_WIDTH deep and (KSIZE−1)*DATA_WIDTH wide, addressed by x. It is read combinationally.
  - The read word holds the previous KSIZE−1 rows at column x.
  - The write-back at the same address is {rows shifted up by one, `in_data`}.
- The window register array is KSIZE×KSIZE. On each accepted pixel, every row shifts left one column. The new right column is {RAM word, `in_data`}.
- Out-of-frame taps are rows r < KSIZE−1−y or columns c < KSIZE−1−x. They are substituted per Configuration, and stale line-store contents are never visible. Substitution applies to the output only; the stored data is untouched.
- No backpressure. Downstream must accept every window.

## Timing
- Latency: 1 cycle. `out_*` register the window for the pixel accepted in the previous cycle.
- `out_valid` = registered `in_valid`. When low, `out_window`/`out_x`/`out_y`/`out_border` hold their previous values.
- Reset (asynchronous assert, synchronous deassert assumed upstream):
  - `out_valid`=0, `out_window`=0, `out_x`=0, `out_y`=0, `out_border`=0.
  - Counters reset to 0, and the next pixel is treated as (0,0).
  - RAM contents are not reset; masking covers them.
- Reset mid-frame: the output drops immediately, and no further windows from the old frame are emitted.
- `in_sof` while `in_valid`=0 is ignored.

## Configuration
- `WINDOW_REPLICATE_EN` undefined: out-of-frame taps output 0.
- `WINDOW_REPLICATE_EN` defined: out-of-frame taps clamp to the nearest in-frame tap.
  - Column clamp first, using column KSIZE−1−x.
  - Then row clamp, using row KSIZE−1−y.
  - The corner therefore replicates pixel (0,0).
- `out_border` behaves identically in both builds.

## Structure
- Shared package `window_pkg` holds:
  - the `clog2` function;
  - the coordinate width constant (16);
  - the KSIZE range limits;
  - a tap-index helper function (r,c)→t.
- One sub-module, `line_buffer_ram`: simple dual-port RAM with asynchronous read and synchronous write, parameterised by depth and width.
- Counters, window array and border masking stay in `window_generator`.

## Test plan
- KSIZE=3, FRAME 4×4, `in_data`=y*4+x, continuous valid. Pixel (2,2) → `out_window` taps 0..8 = {0,1,2,4,5,6,8,9,10}, `out_border`=0, one cycle later.
- Same frame, pixel (0,0):
  - without macro → taps 0..7 = 0, tap 8 = 0, `out_border`=1;
  - with `WINDOW_REPLICATE_EN` → all nine taps = 0 (replicated (0,0));
  - at (1,0) with replicate → rows all {0,0,1}.
- `in_valid` toggled 1,0,0,1 every pixel → `out_valid` mirrors it one cycle late; windows are identical to the continuous run.
- `in_sof` asserted at pixel index 6 of a 4×4 frame → that pixel reports (0,0) with `out_border`=1. Prior rows are masked (zero), not the old data.
- Two back-to-back frames without sof → the second frame's (0,0) has `out_border`=1 and `out_y` wraps to 0.
- `reset_n` low for 1 cycle mid-row → all outputs 0 asynchronously. The first pixel after release reports (0,0).
